// File: rtl/rf_window_sequencer.sv
// rf_window_sequencer
// Loads N words from a valid/ready stream into register-file addresses
// 0..N-1. It then issues three-address reads (i, i+1, i+2) for i = 0..N-3.
// The register file's registered read data is passed straight out as a
// 3-tap window with a valid/ready handshake.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start                      begin a pass (only honoured in IDLE)
//   in_valid/in_data/in_ready  input word stream
//   rf_we/rf_waddr/rf_wdata    registered register-file write port
//   rf_re/rf_raddr1..3         combinational register-file read request
//   rf_rdata1..3               register-file read data (registered in RF)
//   win_valid/win0..2          window out, taps wired to rf_rdata1..3
//   win_ready                  window consumer ready
//   done                       one-cycle pulse after the last window handshake
module rf_window_sequencer #(
    parameter int M = 4,
    parameter int N = 15,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         rf_we,
    output logic [M-1:0] rf_waddr,
    output logic [W-1:0] rf_wdata,
    output logic         rf_re,
    output logic [M-1:0] rf_raddr1,
    output logic [M-1:0] rf_raddr2,
    output logic [M-1:0] rf_raddr3,
    input  logic [W-1:0] rf_rdata1,
    input  logic [W-1:0] rf_rdata2,
    input  logic [W-1:0] rf_rdata3,
    output logic         win_valid,
    output logic [W-1:0] win0,
    output logic [W-1:0] win1,
    output logic [W-1:0] win2,
    input  logic         win_ready,
    output logic         done
);

    // One extra bit so the pointer can count up to N when N == 2^M.
    localparam int CW = M + 1;

    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
    localparam logic [CW-1:0] LAST_RD   = CW'(N - 3);
    localparam logic [CW-1:0] DONE_IDX  = CW'(N - 2);
    localparam logic [M-1:0]  ONE_A     = 1;
    localparam logic [M-1:0]  TWO_A     = 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_SCAN   = 2'd3;

    logic [1:0]    state_q, state_d;
    // Shared pointer: write address during LOAD, window index during SCAN.
    logic [CW-1:0] ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [M-1:0]  waddr_q, waddr_d;
    logic [W-1:0]  wdata_q, wdata_d;
    logic          wv_q, wv_d;
    logic          done_q, done_d;
    logic          accept;

    assign rf_we     = we_q;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign win_valid = wv_q;
    assign done      = done_q;

    // Taps come straight from the register file. They stay stable during a
    // stall because no read is issued while a window is pending.
    assign win0 = rf_rdata1;
    assign win1 = rf_rdata2;
    assign win2 = rf_rdata3;

    assign in_ready = (state_q == S_LOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        rf_re     = (state_q == S_SCAN) && (!wv_q || win_ready) && (ptr_q <= LAST_RD);
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        rf_raddr3 = '0;
        if (state_q == S_SCAN) begin
            rf_raddr1 = ptr_q[M-1:0];
            rf_raddr2 = ptr_q[M-1:0] + ONE_A;
            rf_raddr3 = ptr_q[M-1:0] + TWO_A;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wv_d    = wv_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q[M-1:0];
                    wdata_d = in_data;
                    ptr_d   = ptr_q + 1'b1;
                    if (ptr_q == LAST_BEAT) state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // The final write strobe is out this cycle, so it lands
                // before the first read.
                state_d = S_SCAN;
                ptr_d   = '0;
            end
            default: begin
                if (rf_re) begin
                    wv_d  = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                end else if (win_ready) begin
                    wv_d = 1'b0;
                end
                // Reads are exhausted once ptr reaches N-2, so this
                // handshake is the last window.
                if (wv_q && win_ready && ptr_q == DONE_IDX) begin
                    done_d  = 1'b1;
                    wv_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wv_q    <= wv_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_rf_window_sequencer.sv
module tb_rf_window_sequencer;
    localparam int N = 15;
    localparam int M = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance (N=15) ----------------
    logic       start = 1'b0, in_valid = 1'b0, win_ready = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_ready, rf_we, rf_re, win_valid, done;
    logic [3:0] rf_waddr, rf_raddr1, rf_raddr2, rf_raddr3;
    logic [7:0] rf_wdata, rd1, rd2, rd3, win0, win1, win2;
    logic [7:0] mem [16];

    rf_window_sequencer #(.M(M), .N(N), .W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_re(rf_re), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_raddr3(rf_raddr3),
        .rf_rdata1(rd1), .rf_rdata2(rd2), .rf_rdata3(rd3), .win_valid(win_valid),
        .win0(win0), .win1(win1), .win2(win2), .win_ready(win_ready), .done(done));

    // Register file model: synchronous write, registered read data.
    always @(posedge clk) begin
        if (rf_we) mem[rf_waddr] <= rf_wdata;
        if (rf_re) begin
            rd1 <= mem[rf_raddr1];
            rd2 <= mem[rf_raddr2];
            rd3 <= mem[rf_raddr3];
        end
    end

    // ---------------- small instance (N=3) ----------------
    logic       st3 = 1'b0, iv3 = 1'b0;
    logic [7:0] id3 = '0;
    logic       ir3, we3, re3, wv3, dn3;
    logic [3:0] wa3, ra31, ra32, ra33;
    logic [7:0] wd3, rd31, rd32, rd33, w30, w31, w32;
    logic [7:0] mem3 [16];

    rf_window_sequencer #(.M(M), .N(3), .W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .in_valid(iv3), .in_data(id3),
        .in_ready(ir3), .rf_we(we3), .rf_waddr(wa3), .rf_wdata(wd3),
        .rf_re(re3), .rf_raddr1(ra31), .rf_raddr2(ra32), .rf_raddr3(ra33),
        .rf_rdata1(rd31), .rf_rdata2(rd32), .rf_rdata3(rd33), .win_valid(wv3),
        .win0(w30), .win1(w31), .win2(w32), .win_ready(1'b1), .done(dn3));

    always @(posedge clk) begin
        if (we3) mem3[wa3] <= wd3;
        if (re3) begin
            rd31 <= mem3[ra31];
            rd32 <= mem3[ra32];
            rd33 <= mem3[ra33];
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  wr_a [$];
    logic [7:0]  wr_d [$];
    logic [23:0] wins [$];
    logic [23:0] held;
    int hs_cnt = 0, last_beat_cyc = 0, first_win_cyc = -1, last_hs_cyc = 0;
    int done_cyc = -1, done_cnt = 0, stall_at = -1, stall_left = 0;
    bit stalled = 1'b0;

    // Monitor + consumer for the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_we) begin
                wr_a.push_back(rf_waddr);
                wr_d.push_back(rf_wdata);
                chk("wr_rd_overlap", {31'd0, rf_re}, 32'd0);
            end
            if (in_valid && in_ready) last_beat_cyc = cyc;
            if (win_valid && first_win_cyc < 0) first_win_cyc = cyc;
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
            end
            if (stall_left > 0) begin
                chk("stall_re", {31'd0, rf_re}, 32'd0);
                chk("stall_hold", {8'd0, win0, win1, win2}, {8'd0, held});
                stall_left--;
                if (stall_left == 0) win_ready = 1'b1;
            end else if (!stalled && win_valid && hs_cnt == stall_at) begin
                stalled    = 1'b1;
                win_ready  = 1'b0;
                stall_left = 3;
                held       = {win0, win1, win2};
                chk("stall_win", {8'd0, held}, {8'd0, 8'h14, 8'h15, 8'h16});
            end
            if (win_valid && win_ready) begin
                wins.push_back({win0, win1, win2});
                hs_cnt++;
                last_hs_cyc = cyc;
            end
        end
    end

    int n3_we = 0, n3_win = 0, n3_done = 0, win3_cyc = 0, done3_cyc = 0;
    logic [23:0] win3_val = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (we3) n3_we++;
            if (wv3) begin
                n3_win++;
                win3_val = {w30, w31, w32};
                win3_cyc = cyc;
            end
            if (dn3) begin
                n3_done++;
                done3_cyc = cyc;
            end
        end
    end

    task automatic run_pass(input logic [7:0] base, input bit gaps, input int stl,
                            input bit noise, input int abort_hs);
        wr_a.delete(); wr_d.delete(); wins.delete();
        hs_cnt = 0; first_win_cyc = -1; done_cyc = -1; done_cnt = 0;
        stall_at = stl; stalled = 1'b0; stall_left = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int b = 0; b < N; b++) begin
            int guard = 0;
            bit acc = 1'b0;
            if (gaps) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = base + 8'(b);
            if (noise && b == 5) start = 1'b1;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                guard++;
            end while (!acc && guard < 20);
            if (!acc) chk("load_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = (noise && c == 6);
            if (done || (abort_hs >= 0 && hs_cnt >= abort_hs)) break;
        end
        start = 1'b0;
        if (abort_hs < 0) repeat (3) @(negedge clk);
    endtask

    task automatic check_pass(input logic [7:0] base, input int span);
        chk("n_writes", wr_a.size(), N);
        for (int j = 0; j < N && j < wr_a.size(); j++) begin
            chk("wr_addr", {28'd0, wr_a[j]}, j);
            chk("wr_data", {24'd0, wr_d[j]}, {24'd0, base + 8'(j)});
        end
        chk("n_wins", wins.size(), N - 2);
        for (int j = 0; j < N - 2 && j < wins.size(); j++) begin
            logic [7:0] b0;
            b0 = base + 8'(j);
            chk("window", {8'd0, wins[j]}, {8'd0, b0, b0 + 8'd1, b0 + 8'd2});
        end
        chk("done_cnt", done_cnt, 1);
        chk("done_lat", done_cyc - last_hs_cyc, 1);
        chk("first_win_lat", first_win_cyc - last_beat_cyc, 3);
        chk("scan_span", done_cyc - first_win_cyc, span);
        chk("idle_after", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_we"}, {31'd0, rf_we}, 32'd0);
        chk({nm, "_waddr_wdata"}, {20'd0, rf_waddr, rf_wdata}, 32'd0);
        chk({nm, "_wv_done"}, {30'd0, win_valid, done}, 32'd0);
        chk({nm, "_rdy_re"}, {30'd0, in_ready, rf_re}, 32'd0);
        chk({nm, "_raddr"}, {20'd0, rf_raddr1, rf_raddr2, rf_raddr3}, 32'd0);
    endtask

    typedef struct {
        logic [7:0]  base;
        bit          gaps;
        int          stall;
        bit          noise;
        logic [23:0] exp_first;
        int          exp_span;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{8'h10, 1'b0, -1, 1'b0, 24'h101112, 13};
        vecs[1] = '{8'h10, 1'b1, -1, 1'b0, 24'h101112, 13};
        vecs[2] = '{8'h10, 1'b0,  4, 1'b0, 24'h101112, 16};
        vecs[3] = '{8'h10, 1'b1,  4, 1'b1, 24'h101112, 16};

        #3 check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;

        // in_valid while idle: nothing accepted, nothing written.
        in_valid = 1'b1; in_data = 8'h77;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("idle_in_ready", {30'd0, in_ready, rf_we}, 32'd0);
        end
        in_valid = 1'b0;

        for (int v = 0; v < 4; v++) begin
            run_pass(vecs[v].base, vecs[v].gaps, vecs[v].stall, vecs[v].noise, -1);
            check_pass(vecs[v].base, vecs[v].exp_span);
            chk("first_window", {8'd0, (wins.size() > 0) ? wins[0] : 24'd0}, {8'd0, vecs[v].exp_first});
        end

        // Reset mid-SCAN after window 5, then a fresh pass.
        run_pass(8'h60, 1'b0, -1, 1'b0, 6);
        chk("pre_rst_busy", {31'd0, (rf_re | win_valid)}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midscan_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_pass(8'hA0, 1'b0, -1, 1'b0, -1);
        check_pass(8'hA0, 13);
        chk("rst_first_window", {8'd0, (wins.size() > 0) ? wins[0] : 24'd0}, {8'd0, 24'hA0A1A2});

        // N=3: three back-to-back beats, a single window.
        n3_we = 0; n3_win = 0; n3_done = 0;
        @(posedge clk); #1 st3 = 1'b1;
        @(posedge clk); #1 st3 = 1'b0; iv3 = 1'b1; id3 = 8'h51;
        @(posedge clk); #1 id3 = 8'h52;
        @(posedge clk); #1 id3 = 8'h53;
        @(posedge clk); #1 iv3 = 1'b0;
        repeat (12) @(negedge clk);
        chk("n3_writes", n3_we, 3);
        chk("n3_wins", n3_win, 1);
        chk("n3_window", {8'd0, win3_val}, {8'd0, 24'h515253});
        chk("n3_done_cnt", n3_done, 1);
        chk("n3_done_lat", done3_cyc - win3_cyc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rf_window_sequencer.md
# rf_window_sequencer

Initiator for the CNN single-layer register file. Accepts a stream of N pixel/weight words through a valid/ready port, writes them into register-file addresses 0..N-1, then sweeps three-address read requests (i, i+1, i+2) to produce N-2 sliding 3-tap windows for the convolution datapath. The register file's registered read data is passed through as the window. Backpressure is honoured without loss.

## Interface
- M, 4, register-file address width
- N, 15, words loaded per pass (N ≥ 3, N ≤ 2^M)
- W, 8, data width
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a pass; sampled only in IDLE
- in_valid  input  1  input word valid
- in_data  input  W  input word
- in_ready  output  1  block accepts a word this cycle
- rf_we  output  1  register-file WriteEn (registered)
- rf_waddr  output  M  register-file WriteReg (registered)
- rf_wdata  output  W  register-file WriteData (registered)
- rf_re  output  1  register-file ReadEn (combinational)
- rf_raddr1, rf_raddr2, rf_raddr3  output  M each  ReadReg1/2/3 (combinational)
- rf_rdata1, rf_rdata2, rf_rdata3  input  W each  ReadData1/2/3 from register file
- win_valid  output  1  window valid (registered)
- win0, win1, win2  output  W each  window taps; wired directly to rf_rdata1/2/3
- win_ready  input  1  consumer accepts window
- done  output  1  one-cycle pulse after last window handshake

## Operation
- States: IDLE, LOAD, SETTLE, SCAN.
- IDLE: in_ready=0, rf_re=0. start=1 → LOAD, write counter cleared to 0.
- LOAD: in_ready=1. Beat accepted on in_valid&&in_ready; next cycle rf_we=1, rf_waddr=counter, rf_wdata=in_data; counter+1. Gaps in in_valid allowed; rf_we=0 on cycles with no accepted beat. On the N-th beat → SETTLE; in_ready=0 from the following cycle.
- SETTLE: exactly one cycle; carries the final write strobe so it commits before any read. → SCAN, window index i=0.
- SCAN: rf_re = (!win_valid || win_ready) && (i ≤ N-3); rf_raddr1/2/3 = i, i+1, i+2 (M-bit, never wraps since i ≤ N-3). Each rf_re cycle: i+1, win_valid set at next edge.
- win_valid clears on handshake with no new read issued. When win_valid && !win_ready, rf_re=0, so rf_rdata (and win0..2) hold stable.
- After handshake of window i=N-3: done=1 next cycle, state → IDLE, win_valid=0.
- start outside IDLE ignored. in_valid outside LOAD ignored (in_ready=0).
- Writes and reads never overlap in the same cycle.

## Timing
- Reset (async, rst_n=0): state IDLE, counters 0, rf_we=0, rf_waddr=0, rf_wdata=0, win_valid=0, done=0; combinational outputs in_ready=0, rf_re=0, rf_raddr*=0. Reset mid-pass abandons it; register-file contents left as-is.
- start sampled at edge s → in_ready=1 in cycle after s.
- Beat accepted at edge k → rf_we high in cycle k..k+1, write commits at edge k+1.
- Last beat at edge k: SETTLE cycle k..k+1, first rf_re cycle k+1..k+2, win_valid=1 after edge k+2.
- Throughput: one window per cycle with win_ready held 1; N-2 windows total.
- done high exactly one cycle, in the cycle after the final window handshake.

## Test plan
- N=15, W=8, start, stream 0x10..0x1E back-to-back, win_ready=1 -> 15 writes to addr 0..14; windows (0x10,0x11,0x12)..(0x1C,0x1D,0x1E), 13 consecutive win_valid cycles starting 2 cycles after last beat; done one cycle after last.
- Same load with in_valid toggling every other cycle -> writes only on accepted beats, addresses still 0..14 contiguous, identical windows.
- win_ready low for 3 cycles on window i=4 -> rf_re=0 during stall, win0..2 hold (0x14,0x15,0x16), no window dropped or duplicated, 13 total.
- start pulsed during LOAD and SCAN -> ignored; in_valid asserted in IDLE -> in_ready=0, no rf_we.
- rst_n low mid-SCAN (after window 5) -> all outputs to reset values immediately; new start then reload 0xA0..0xAE -> first window (0xA0,0xA1,0xA2).
- N=3 -> 3 writes, single window, done one cycle after its handshake.
